// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU/writeback selects, fault codes and phase indices.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_LD  = 4'd5;
   localparam logic [3:0] OP_ST  = 4'd6;
   localparam logic [3:0] OP_LI  = 4'd7;
   localparam logic [3:0] OP_JMP = 4'd8;
   localparam logic [3:0] OP_BZ  = 4'd9;
   localparam logic [3:0] OP_HLT = 4'd15;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_DMEM = 2'd1;
   localparam logic [1:0] WB_IMM  = 2'd2;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_ILLEGAL = 2'd1;
   localparam logic [1:0] FC_BAD_PH  = 2'd2;

   localparam int P_FETCH = 0;
   localparam int P_DEC   = 1;
   localparam int P_EXEC  = 2;
   localparam int P_MEM   = 3;
   localparam int P_WB    = 4;

   // Opcodes 10..14 are unassigned.
   function automatic logic op_illegal(input logic [3:0] op);
      return (op >= 4'd10) && (op <= 4'd14);
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/phase_check.sv
// Flags a phase vector with more than one bit set; all-zero (idle) is legal.
module phase_check (
   input  logic [4:0] phase_i,
   output logic       bad_phase_o
);

   // x & (x-1) clears the lowest set bit; anything left means a second bit was set.
   assign bad_phase_o = |(phase_i & (phase_i - 5'd1));

endmodule

// File: rtl/phase_seq.sv
// Control sequencer: latches the instruction, decodes per-phase datapath strobes,
// and raises a sticky halt on HLT, illegal opcode or a malformed phase vector.
module phase_seq
   import cpu_pkg::*;
#(
   parameter int IW    = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [4:0]       phase_i,
   input  logic [IW-1:0]    imem_data_i,
   input  logic             flag_z_i,
   output logic [IW-1:0]    ir_o,
   output logic             ir_we_o,
   output logic             pc_inc_o,
   output logic             pc_load_o,
   output logic             reg_re_o,
   output logic             alu_en_o,
   output logic             dmem_re_o,
   output logic             dmem_we_o,
   output logic             reg_we_o,
   output logic [2:0]       alu_op_o,
   output logic [1:0]       wb_sel_o,
   output logic             hlt_o,
   output logic             fault_o,
   output logic [1:0]       fault_code_o,
   output logic [CNT_W-1:0] retired_o
);

   logic             bad_phase;
   logic [4:0]       ph;
   logic [3:0]       op;
   logic             is_alu, is_ld, is_st, is_li, is_jmp, is_bz, is_hlt, is_ill, take_br;

   logic [IW-1:0]    ir_q, ir_d;
   logic             hlt_q, hlt_d;
   logic             fault_q, fault_d;
   logic [1:0]       fault_code_q, fault_code_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             zflag_q, zflag_d;

   phase_check u_phase_check (
      .phase_i     (phase_i),
      .bad_phase_o (bad_phase)
   );

   // Qualified phase: nothing is issued once halted or while the vector is malformed.
   assign ph = (hlt_q || bad_phase) ? 5'd0 : phase_i;
   assign op = ir_q[IW-1 -: 4];

   always_comb begin
      is_alu  = (op >= OP_ADD) && (op <= OP_OR);
      is_ld   = (op == OP_LD);
      is_st   = (op == OP_ST);
      is_li   = (op == OP_LI);
      is_jmp  = (op == OP_JMP);
      is_bz   = (op == OP_BZ);
      is_hlt  = (op == OP_HLT);
      is_ill  = op_illegal(op);
      take_br = is_jmp || (is_bz && zflag_q);
   end

   always_comb begin
      ir_d         = ir_q;
      hlt_d        = hlt_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      retired_d    = retired_q;
      zflag_d      = zflag_q;

      if (ph[P_FETCH]) ir_d = imem_data_i;
      if (ph[P_EXEC])  zflag_d = flag_z_i;
      if (ph[P_MEM] && is_hlt) hlt_d = 1'b1;
      if (ph[P_WB])    retired_d = retired_q + CNT_W'(1);

      // Bad phase outranks an illegal opcode detected on the same edge.
      if (bad_phase) begin
         hlt_d = 1'b1;
         if (!fault_q) begin
            fault_d      = 1'b1;
            fault_code_d = FC_BAD_PH;
         end
      end else if (ph[P_DEC] && is_ill) begin
         hlt_d = 1'b1;
         if (!fault_q) begin
            fault_d      = 1'b1;
            fault_code_d = FC_ILLEGAL;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ir_q         <= '0;
         hlt_q        <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
         retired_q    <= '0;
         zflag_q      <= 1'b0;
      end else begin
         ir_q         <= ir_d;
         hlt_q        <= hlt_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         retired_q    <= retired_d;
         zflag_q      <= zflag_d;
      end
   end

   always_comb begin
      ir_we_o   = ph[P_FETCH];
      reg_re_o  = ph[P_DEC];
      alu_en_o  = ph[P_EXEC] && is_alu;
      dmem_re_o = ph[P_MEM] && is_ld;
      dmem_we_o = ph[P_MEM] && is_st;
      reg_we_o  = ph[P_WB] && (is_alu || is_ld || is_li);
      pc_load_o = ph[P_WB] && take_br;
      pc_inc_o  = ph[P_WB] && !take_br && !is_hlt && !is_ill;
      alu_op_o  = alu_en_o ? alu_code(op) : ALU_ADD;
      wb_sel_o  = WB_ALU;
      if (reg_we_o && is_ld) wb_sel_o = WB_DMEM;
      if (reg_we_o && is_li) wb_sel_o = WB_IMM;
   end

   assign ir_o         = ir_q;
   assign hlt_o        = hlt_q;
   assign fault_o      = fault_q;
   assign fault_code_o = fault_code_q;
   assign retired_o    = retired_q;

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq: drives phase vectors and instructions, checks strobes and status.
module tb_phase_seq;

   localparam int IW    = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             n_rst;
   logic [4:0]       phase;
   logic [IW-1:0]    imem_data;
   logic             flag_z;
   logic [IW-1:0]    ir;
   logic             ir_we, pc_inc, pc_load, reg_re, alu_en, dmem_re, dmem_we, reg_we;
   logic [2:0]       alu_op;
   logic [1:0]       wb_sel;
   logic             hlt, fault;
   logic [1:0]       fault_code;
   logic [CNT_W-1:0] retired;
   logic [7:0]       strb;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   phase_seq #(.IW(IW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .phase_i      (phase),
      .imem_data_i  (imem_data),
      .flag_z_i     (flag_z),
      .ir_o         (ir),
      .ir_we_o      (ir_we),
      .pc_inc_o     (pc_inc),
      .pc_load_o    (pc_load),
      .reg_re_o     (reg_re),
      .alu_en_o     (alu_en),
      .dmem_re_o    (dmem_re),
      .dmem_we_o    (dmem_we),
      .reg_we_o     (reg_we),
      .alu_op_o     (alu_op),
      .wb_sel_o     (wb_sel),
      .hlt_o        (hlt),
      .fault_o      (fault),
      .fault_code_o (fault_code),
      .retired_o    (retired)
   );

   // [7]ir_we [6]pc_inc [5]pc_load [4]reg_re [3]alu_en [2]dmem_re [1]dmem_we [0]reg_we
   assign strb = {ir_we, pc_inc, pc_load, reg_re, alu_en, dmem_re, dmem_we, reg_we};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Present one phase, check strobes mid-cycle, then advance past the edge.
   task automatic do_phase(input int idx, input logic [IW-1:0] data, input logic z,
                           input logic [7:0] exp_s, input logic [2:0] aop, input logic [1:0] wb);
      logic [4:0] one;
      one       = 5'd1;
      phase     = one << idx;
      imem_data = data;
      flag_z    = z;
      @(negedge clk);
      chk($sformatf("strobes op%0h p%0d", data[15:12], idx), {24'd0, strb}, {24'd0, exp_s});
      if (idx == 2 && exp_s[3]) chk("alu_op", {29'd0, alu_op}, {29'd0, aop});
      if (idx == 4 && exp_s[0]) chk("wb_sel", {30'd0, wb_sel}, {30'd0, wb});
      @(posedge clk); #1;
   endtask

   task automatic run_instr(input logic [IW-1:0] instr, input logic z, input logic [39:0] exp,
                            input logic [2:0] aop, input logic [1:0] wb);
      for (int i = 0; i < 5; i++) do_phase(i, instr, z, exp[39-8*i -: 8], aop, wb);
      phase = 5'd0;
      exp_ret++;
      chk("retired", {16'd0, retired}, exp_ret);
      chk("ir", {16'd0, ir}, {16'd0, instr});
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      phase = 5'd0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      exp_ret = 0;
   endtask

   initial begin
      imem_data = '0;
      flag_z    = 1'b0;
      do_reset();
      @(negedge clk);
      chk("rst ir", {16'd0, ir}, 32'd0);
      chk("rst hlt", {31'd0, hlt}, 32'd0);
      chk("rst fault", {31'd0, fault}, 32'd0);
      chk("rst code", {30'd0, fault_code}, 32'd0);
      chk("rst retired", {16'd0, retired}, 32'd0);
      chk("rst strobes", {24'd0, strb}, 32'd0);
      @(posedge clk); #1;

      // instr, z, strobes P0..P4, alu_op, wb_sel
      run_instr(16'h1123, 1'b0, 40'h80_10_08_00_41, 3'd0, 2'd0);
      run_instr(16'h2456, 1'b0, 40'h80_10_08_00_41, 3'd1, 2'd0);
      run_instr(16'h3000, 1'b0, 40'h80_10_08_00_41, 3'd2, 2'd0);
      run_instr(16'h4000, 1'b0, 40'h80_10_08_00_41, 3'd3, 2'd0);
      run_instr(16'h5000, 1'b0, 40'h80_10_00_04_41, 3'd0, 2'd1);
      run_instr(16'h6000, 1'b0, 40'h80_10_00_02_40, 3'd0, 2'd0);
      run_instr(16'h7000, 1'b0, 40'h80_10_00_00_41, 3'd0, 2'd2);
      run_instr(16'h8000, 1'b0, 40'h80_10_00_00_20, 3'd0, 2'd0);
      run_instr(16'h9000, 1'b1, 40'h80_10_00_00_20, 3'd0, 2'd0);
      run_instr(16'h9000, 1'b0, 40'h80_10_00_00_40, 3'd0, 2'd0);
      run_instr(16'h0000, 1'b0, 40'h80_10_00_00_40, 3'd0, 2'd0);

      // HLT: rises at the edge ending P3, no writeback strobes, no retire.
      do_phase(0, 16'hF000, 1'b0, 8'h80, 3'd0, 2'd0);
      do_phase(1, 16'hF000, 1'b0, 8'h10, 3'd0, 2'd0);
      do_phase(2, 16'hF000, 1'b0, 8'h00, 3'd0, 2'd0);
      chk("hlt before P3 end", {31'd0, hlt}, 32'd0);
      do_phase(3, 16'hF000, 1'b0, 8'h00, 3'd0, 2'd0);
      chk("hlt in P4", {31'd0, hlt}, 32'd1);
      chk("hlt no fault", {31'd0, fault}, 32'd0);
      do_phase(4, 16'hF000, 1'b0, 8'h00, 3'd0, 2'd0);
      phase = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("hlt sticky", {31'd0, hlt}, 32'd1);
      chk("hlt retired", {16'd0, retired}, exp_ret);
      do_phase(0, 16'h1123, 1'b0, 8'h00, 3'd0, 2'd0);
      chk("hlt ir frozen", {16'd0, ir}, 32'h0000F000);

      // Illegal opcode, then a bad phase vector: first fault code sticks.
      do_reset();
      do_phase(0, 16'hA000, 1'b0, 8'h80, 3'd0, 2'd0);
      do_phase(1, 16'hA000, 1'b0, 8'h10, 3'd0, 2'd0);
      chk("ill hlt", {31'd0, hlt}, 32'd1);
      chk("ill fault", {31'd0, fault}, 32'd1);
      chk("ill code", {30'd0, fault_code}, 32'd1);
      do_phase(2, 16'hA000, 1'b0, 8'h00, 3'd0, 2'd0);
      do_phase(3, 16'hA000, 1'b0, 8'h00, 3'd0, 2'd0);
      do_phase(4, 16'hA000, 1'b0, 8'h00, 3'd0, 2'd0);
      chk("ill retired", {16'd0, retired}, 32'd0);
      do_phase(0, 16'h1123, 1'b0, 8'h00, 3'd0, 2'd0);
      phase = 5'b00011;
      @(negedge clk);
      chk("bad after ill strobes", {24'd0, strb}, 32'd0);
      @(posedge clk); #1;
      phase = 5'd0;
      chk("code kept 1", {30'd0, fault_code}, 32'd1);

      // Illegal opcode and bad phase on the same edge: bad phase code wins.
      do_reset();
      do_phase(0, 16'hB000, 1'b0, 8'h80, 3'd0, 2'd0);
      phase = 5'b00011;
      @(negedge clk);
      chk("bad strobes gated", {24'd0, strb}, 32'd0);
      chk("bad hlt not yet", {31'd0, hlt}, 32'd0);
      @(posedge clk); #1;
      phase = 5'd0;
      chk("bad hlt", {31'd0, hlt}, 32'd1);
      chk("bad fault", {31'd0, fault}, 32'd1);
      chk("bad code", {30'd0, fault_code}, 32'd2);

      // Reset pulse during P2 of an ADD abandons the instruction.
      do_reset();
      do_phase(0, 16'h1123, 1'b0, 8'h80, 3'd0, 2'd0);
      do_phase(1, 16'h1123, 1'b0, 8'h10, 3'd0, 2'd0);
      phase = 5'b00100;
      #1;
      chk("pre-rst alu_en", {31'd0, alu_en}, 32'd1);
      n_rst = 1'b0;
      #1;
      chk("mid-rst ir", {16'd0, ir}, 32'd0);
      chk("mid-rst hlt", {31'd0, hlt}, 32'd0);
      chk("mid-rst retired", {16'd0, retired}, 32'd0);
      chk("mid-rst strobes", {24'd0, strb}, 32'd0);
      #1 n_rst = 1'b1;
      @(posedge clk); #1;
      phase = 5'b01000;
      @(posedge clk); #1;
      phase = 5'b10000;
      @(negedge clk);
      chk("mid-rst no reg_we", {31'd0, reg_we}, 32'd0);
      @(posedge clk); #1;
      phase = 5'd0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/phase_seq.md
# phase_seq

Control sequencer at the consuming end of the 5-phase one-hot bus from the phase generator. Latches the fetched instruction, decodes it against the current phase into per-phase datapath strobes, and drives the `hlt` request back to the phase generator on an HLT instruction, an illegal opcode, or a malformed phase vector. Sits between the phase generator and the CPU datapath.

## Interface
- `IW`, 16, instruction width; opcode is `ir[IW-1:IW-4]`.
- `CNT_W`, 16, retired-instruction counter width.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `phase`  in  5  one-hot phase from the phase generator; 0 = idle.
- `imem_data`  in  IW  instruction memory read data, valid during phase[0].
- `flag_z`  in  1  ALU zero flag, sampled in phase[2].
- `ir`  out  IW  latched instruction register.
- `ir_we`, `pc_inc`, `pc_load`, `reg_re`, `alu_en`, `dmem_re`, `dmem_we`, `reg_we`  out  1 each  datapath strobes.
- `alu_op`  out  3  ALU function.
- `wb_sel`  out  2  writeback source: 0 ALU, 1 dmem, 2 immediate.
- `hlt`  out  1  halt request to the phase generator; sticky.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  0 none, 1 illegal opcode, 2 bad phase.
- `retired`  out  CNT_W  count of completed non-HLT instructions.

## Operation
- Phase roles: P0 fetch (`ir_we`), P1 decode/register read (`reg_re`), P2 execute (`alu_en`, branch resolve), P3 memory (`dmem_re`/`dmem_we`), P4 writeback (`reg_we`, `pc_inc`).
- `ir` loads `imem_data` at the clock edge ending P0; all other strobes decode combinationally from `phase` and `ir`.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LD, 6 ST, 7 LI, 8 JMP, 9 BZ, 15 HLT; 10–14 are illegal.
- `alu_op`: ADD 0, SUB 1, AND 2, OR 3; otherwise 0. `alu_en` in P2 for opcodes 1–4 only.
- LD: `dmem_re` in P3, `reg_we` in P4 with `wb_sel`=1. ST: `dmem_we` in P3, no `reg_we`. LI: `reg_we` in P4 with `wb_sel`=2. ALU ops: `reg_we` in P4 with `wb_sel`=0.
- JMP: `pc_load` in P4 and no `pc_inc`. BZ: `flag_z` is registered at the end of P2; in P4, assert `pc_load` if the registered flag is 1, else `pc_inc`. All other opcodes assert `pc_inc` in P4.
- HLT: set `hlt` at the clock edge ending P3, so it is high throughout P4. No strobes are issued for HLT except `ir_we` and `reg_re`.
- Illegal opcode: at the edge ending P1, set `hlt`, `fault`, and `fault_code`=1. All P2–P4 strobes for that instruction are suppressed.
- Bad phase: more than one `phase` bit set sets `hlt`, `fault`, and `fault_code`=2 at the next edge. All strobes are gated off while the phase vector is bad.
- `hlt`, `fault`, and `fault_code` clear only on `n_rst`. The first fault wins; `fault_code` is never overwritten.
- `retired` increments at the edge ending P4 for every instruction with `hlt` low. It wraps modulo 2^CNT_W.

## Timing
- Reset values: `ir`=0, `hlt`=0, `fault`=0, `fault_code`=0, `retired`=0, registered zero flag 0. All strobes are 0 because `phase`=0 while idle.
- `phase`=0: no strobes; state holds.
- Latency: fetch to writeback is 5 cycles; `hlt` reaches the phase generator 1 cycle before the end of the HLT instruction.
- `n_rst` asserted mid-instruction: all registers clear asynchronously and strobes drop immediately; a partially executed instruction is abandoned.
- Simultaneous illegal opcode and bad phase on the same edge: `fault_code`=2.
- After `hlt` is set, all strobes stay low even if `phase` keeps toggling.

## Structure
- Shared package `cpu_pkg`: opcode constants, `alu_op` codes, `wb_sel` codes, `fault_code` values, and phase index names P_FETCH..P_WB.
- One sub-module, `phase_check`: one-hot/zero validator producing a `bad_phase` pulse. Decode logic and registers stay in `phase_seq`.

## Test plan
- ADD `0x1123` over P0–P4: `ir_we` in P0, `alu_en` with `alu_op`=0 in P2, `reg_we` with `wb_sel`=0 plus `pc_inc` in P4; `retired` goes 0→1.
- LD then ST: `dmem_re` in P3 then `reg_we` with `wb_sel`=1 in P4; ST gives `dmem_we` in P3 and no `reg_we`.
- BZ with `flag_z`=1 in P2 gives `pc_load`=1 and `pc_inc`=0 in P4; with `flag_z`=0 gives `pc_inc`=1.
- HLT `0xF000`: `hlt` rises at the end of P3; with `phase` forced to 0 afterward, `hlt` stays 1 and `retired` is unchanged.
- Opcode 0xA, then `phase`=5'b00011 on a later instruction: `fault_code`=1 at the end of P1; no P2–P4 strobes; code stays 1 after the bad phase.
- `n_rst` pulse during P2 of an ADD: `ir`, `hlt`, and `retired` read 0 immediately and no `reg_we` follows.
